// File: rtl/gradient_magnitude_pipe.sv
// Gradient magnitude |G| = sqrt(gx^2 + gy^2) with a fully pipelined non-restoring square root.
// Optional edge threshold output is enabled by defining MODULUS_THRESH_EN.
module gradient_magnitude_pipe #(
  parameter int IN_W      = 11,
  parameter int FRAC_BITS = 3,
  parameter int SB_W      = 2
) (
  input  logic                      pclk,
  input  logic                      resetn,
  input  logic [IN_W-1:0]           gx,
  input  logic [IN_W-1:0]           gy,
  input  logic                      de,
  input  logic [SB_W-1:0]           sb_in,
`ifdef MODULUS_THRESH_EN
  input  logic [IN_W+FRAC_BITS-1:0] thresh_in,
  output logic                      edgeOut,
`endif
  output logic [IN_W+FRAC_BITS-1:0] modulusOut,
  output logic                      deOut,
  output logic [SB_W-1:0]           sb_out
);

  localparam int OUT_W = IN_W + FRAC_BITS;
  localparam int LAT   = 2 + OUT_W;
  localparam int SQ_W  = 2 * IN_W;
  localparam int RAD_W = 2 * OUT_W;
  localparam int REM_W = OUT_W + 2;

  // Reset asserts asynchronously but is released on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_n_int;

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n_int = rst_sync[1];

  logic signed [SQ_W-1:0] gx_ext, gy_ext;
  logic [SQ_W-1:0]        sq_x, sq_y;
  logic                   de_s0;

  assign gx_ext = {{(SQ_W-IN_W){gx[IN_W-1]}}, gx};
  assign gy_ext = {{(SQ_W-IN_W){gy[IN_W-1]}}, gy};

  // Index 0 holds the S1 result; index j>0 holds the state after j root bits.
  logic [REM_W-1:0] rem_q  [0:OUT_W-1];
  logic [OUT_W-1:0] root_q [0:OUT_W-1];
  logic [RAD_W-1:0] rad_q  [0:OUT_W-1];
  logic             de_q   [0:OUT_W-1];

  logic [REM_W-1:0] rem_d  [0:OUT_W-2];
  logic [OUT_W-1:0] root_d [0:OUT_W-2];
  logic [RAD_W-1:0] rad_d  [0:OUT_W-2];
  logic [REM_W-1:0] rem_last;
  logic [OUT_W-1:0] mod_d;

  // One non-restoring step: remainder sign picks add or subtract of the trial root.
  function automatic logic [REM_W-1:0] rem_step(input logic [REM_W-1:0] rem,
                                                input logic [OUT_W-1:0] root,
                                                input logic [1:0]       pair);
    logic [REM_W-1:0] trial;
    trial = {rem[REM_W-3:0], pair};
    if (rem[REM_W-1]) rem_step = trial + {root, 2'b11};
    else              rem_step = trial - {root, 2'b01};
  endfunction

  always_comb begin
    for (int j = 0; j < OUT_W-1; j++) begin
      rem_d[j]  = rem_step(rem_q[j], root_q[j], rad_q[j][RAD_W-1 -: 2]);
      root_d[j] = {root_q[j][OUT_W-2:0], ~rem_d[j][REM_W-1]};
      rad_d[j]  = rad_q[j] << 2;
    end
    rem_last = rem_step(rem_q[OUT_W-1], root_q[OUT_W-1], rad_q[OUT_W-1][RAD_W-1 -: 2]);
    mod_d    = {root_q[OUT_W-1][OUT_W-2:0], ~rem_last[REM_W-1]};
  end

  always_ff @(posedge pclk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      sq_x       <= '0;
      sq_y       <= '0;
      de_s0      <= 1'b0;
      for (int j = 0; j < OUT_W; j++) begin
        rem_q[j]  <= '0;
        root_q[j] <= '0;
        rad_q[j]  <= '0;
        de_q[j]   <= 1'b0;
      end
      modulusOut <= '0;
      deOut      <= 1'b0;
`ifdef MODULUS_THRESH_EN
      edgeOut    <= 1'b0;
`endif
    end else begin
      sq_x      <= gx_ext * gx_ext;
      sq_y      <= gy_ext * gy_ext;
      de_s0     <= de;
      rem_q[0]  <= '0;
      root_q[0] <= '0;
      rad_q[0]  <= {sq_x + sq_y, {(2*FRAC_BITS){1'b0}}};
      de_q[0]   <= de_s0;
      for (int j = 1; j < OUT_W; j++) begin
        rem_q[j]  <= rem_d[j-1];
        root_q[j] <= root_d[j-1];
        rad_q[j]  <= rad_d[j-1];
        de_q[j]   <= de_q[j-1];
      end
      modulusOut <= mod_d;
      deOut      <= de_q[OUT_W-1];
`ifdef MODULUS_THRESH_EN
      edgeOut    <= de_q[OUT_W-1] & (mod_d >= thresh_in);
`endif
    end
  end

  // Sideband rides a plain shift register of the same depth, independent of de.
  logic [SB_W-1:0] sb_q [0:LAT-1];

  always_ff @(posedge pclk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      for (int i = 0; i < LAT; i++) sb_q[i] <= '0;
    end else begin
      sb_q[0] <= sb_in;
      for (int i = 1; i < LAT; i++) sb_q[i] <= sb_q[i-1];
    end
  end

  assign sb_out = sb_q[LAT-1];

endmodule

// File: tb/tb_gradient_magnitude_pipe.sv
// Scoreboard bench for gradient_magnitude_pipe: driver pushes expected magnitudes,
// a negedge monitor pops and compares whenever deOut is high.
module tb_gradient_magnitude_pipe;

  localparam int IN_W      = 11;
  localparam int FRAC_BITS = 3;
  localparam int SB_W      = 2;
  localparam int OUT_W     = IN_W + FRAC_BITS;
  localparam int LAT       = 2 + OUT_W;

  logic              pclk;
  logic              resetn;
  logic [IN_W-1:0]   gx, gy;
  logic              de;
  logic [SB_W-1:0]   sb_in;
  logic [OUT_W-1:0]  modulusOut;
  logic              deOut;
  logic [SB_W-1:0]   sb_out;
`ifdef MODULUS_THRESH_EN
  logic [OUT_W-1:0]  thresh_in;
  logic              edgeOut;
`endif

  gradient_magnitude_pipe #(.IN_W(IN_W), .FRAC_BITS(FRAC_BITS), .SB_W(SB_W)) dut (
    .pclk       (pclk),
    .resetn     (resetn),
    .gx         (gx),
    .gy         (gy),
    .de         (de),
    .sb_in      (sb_in),
`ifdef MODULUS_THRESH_EN
    .thresh_in  (thresh_in),
    .edgeOut    (edgeOut),
`endif
    .modulusOut (modulusOut),
    .deOut      (deOut),
    .sb_out     (sb_out)
  );

  // ---------------- clock / reset ----------------
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [OUT_W-1:0] exp_q[$];
  int               cyc_q[$];
  logic [SB_W-1:0]  sb_model [0:LAT-1];

  always @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < LAT; i++) sb_model[i] <= '0;
    end else begin
      sb_model[0] <= sb_in;
      for (int i = 1; i < LAT; i++) sb_model[i] <= sb_model[i-1];
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Reference: bitwise search for the largest r with r*r <= v.
  function automatic logic [OUT_W-1:0] isqrt(input longint v);
    longint r, t;
    r = 0;
    for (int b = OUT_W-1; b >= 0; b--) begin
      t = r + (longint'(1) << b);
      if (t * t <= v) r = t;
    end
    return r[OUT_W-1:0];
  endfunction

  function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] x, input logic [IN_W-1:0] y);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return isqrt((sx*sx + sy*sy) << (2*FRAC_BITS));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [IN_W-1:0] x, input logic [IN_W-1:0] y, input logic d,
                       input logic [SB_W-1:0] sb, input logic [OUT_W-1:0] e);
    @(posedge pclk);
    #1;
    gx = x; gy = y; de = d; sb_in = sb;
    if (d) begin
      exp_q.push_back(e);
      cyc_q.push_back(cyc + LAT);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, '0, 1'b0, '0, '0);
  endtask

  task automatic drive_rand(input logic d);
    logic [IN_W-1:0] x, y;
    x = IN_W'($urandom_range(0, (1 << IN_W) - 1));
    y = IN_W'($urandom_range(0, (1 << IN_W) - 1));
    drive(x, y, d, SB_W'($urandom_range(0, 3)), model(x, y));
  endtask

  // ---------------- monitor ----------------
  always @(negedge pclk) begin
    if (resetn) begin
      check("sb_out", int'(sb_out), int'(sb_model[LAT-1]));
      if (deOut) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL deout_spurious actual=1 required=0 at cycle %0d", cyc);
        end else begin
          logic [OUT_W-1:0] e;
          int c;
          e = exp_q.pop_front();
          c = cyc_q.pop_front();
          check("modulus", int'(modulusOut), int'(e));
          check("latency", cyc, c);
`ifdef MODULUS_THRESH_EN
          check("edge", int'(edgeOut), (e >= thresh_in) ? 1 : 0);
`endif
        end
      end else begin
`ifdef MODULUS_THRESH_EN
        check("edge_bubble", int'(edgeOut), 0);
`endif
        if (cyc_q.size() != 0 && cyc_q[0] == cyc) begin
          checks++;
          errors++;
          $display("FAIL deout_missing actual=0 required=1 at cycle %0d", cyc);
          void'(exp_q.pop_front());
          void'(cyc_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    resetn = 1'b0;
    gx = '0; gy = '0; de = 1'b0; sb_in = '0;
`ifdef MODULUS_THRESH_EN
    thresh_in = 14'd40;
`endif
    repeat (3) @(posedge pclk);
    #1;
    check("reset_modulus", int'(modulusOut), 0);
    check("reset_deout", int'(deOut), 0);
    check("reset_sb", int'(sb_out), 0);
    resetn = 1'b1;
    idle(3);

    // Directed: 11'h400 = -1024, 11'h7f9 = -7.
    drive(11'd3,   11'd4,   1'b1, 2'd1, 14'd40);
    idle(1);
    drive(11'h400, 11'h400, 1'b1, 2'd2, 14'd11585);
    drive(11'd0,   11'd0,   1'b1, 2'd3, 14'd0);
    drive(11'd1,   11'd1,   1'b1, 2'd0, 14'd11);
    drive(11'h7f9, 11'd0,   1'b1, 2'd1, 14'd56);
    drive(11'd3,   11'd3,   1'b1, 2'd2, 14'd33);
    idle(2);

    // Random mix of full-rate bursts and de gaps.
    for (int i = 0; i < 200; i++) drive_rand($urandom_range(0, 3) != 0);
    for (int i = 0; i < 40; i++)  drive_rand(1'b1);

    // Mid-stream reset: in-flight samples must vanish.
    for (int i = 0; i < 5; i++) drive_rand(1'b1);
    @(posedge pclk);
    #1;
    de = 1'b0; sb_in = '0;
    resetn = 1'b0;
    #1;
    check("rst_modulus", int'(modulusOut), 0);
    check("rst_deout", int'(deOut), 0);
    check("rst_sb", int'(sb_out), 0);
    exp_q.delete();
    cyc_q.delete();
    @(posedge pclk);
    #1;
    resetn = 1'b1;
    idle(3);
    drive(11'd3,   11'd4, 1'b1, 2'd3, 14'd40);
    drive(11'h7f9, 11'd0, 1'b1, 2'd1, 14'd56);
    idle(1);

    for (int i = 0; i < LAT + 8 && exp_q.size() != 0; i++) @(posedge pclk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0 outstanding", exp_q.size());
    end
    repeat (2) @(negedge pclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
